// File: rtl/sample_word_packer_if.sv
// Bit-stream packer bundle: upstream bit/strobe/flush inputs plus the
// downstream valid/ready word port and status flags.
//   slave  : packer side (consumes bits, produces words)
//   master : driver/consumer side
interface sample_word_packer_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             i_bit;
   logic             i_stb;
   logic             i_flush;
   logic [WIDTH-1:0] o_data;
   logic [CW-1:0]    o_cnt;
   logic             o_valid;
   logic             o_ready;
   logic             o_ovf;
   logic             o_busy;

   modport slave (
      input  i_bit, i_stb, i_flush, o_ready,
      output o_data, o_cnt, o_valid, o_ovf, o_busy
   );

   modport master (
      output i_bit, i_stb, i_flush, o_ready,
      input  o_data, o_cnt, o_valid, o_ovf, o_busy
   );
endinterface

// File: rtl/sample_word_packer.sv
// Packs a strobed bit stream into WIDTH-bit words (optionally flushed early
// as a partial word) and queues them in a 2-entry valid/ready output buffer.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : sample_word_packer_if.slave
//            i_bit/i_stb/i_flush in, o_data/o_cnt/o_valid out, o_ready in,
//            o_ovf (sticky drop flag), o_busy (partial word in progress)
module sample_word_packer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic                  clk,
   input logic                  reset,
   sample_word_packer_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   // packer state
   logic [CW-1:0]    cnt_q, cnt_app, cnt_d;
   logic [WIDTH-1:0] shreg_q, word_app, shreg_d;
   logic             push;
   int unsigned      bit_pos;

   // output buffer state: head is what the consumer sees, tail is the spare
   logic [WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [CW-1:0]    head_cnt_q, head_cnt_d, tail_cnt_q, tail_cnt_d;
   logic [1:0]       occ_q, occ_d;
   logic             valid_q, ovf_q, ovf_d, busy_q;
   logic             pop;

   // Append the strobed bit, then decide whether a word (full or flushed) leaves.
   always_comb begin
      bit_pos  = MSB_FIRST ? (WIDTH - 1 - 32'(cnt_q)) : 32'(cnt_q);
      word_app = shreg_q;
      cnt_app  = cnt_q;
      if (bus.i_stb) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i == bit_pos) word_app[i] = bus.i_bit;
         end
         cnt_app = cnt_q + CW'(1);
      end
      // A completing bit wins over flush, so strobe+flush yields one word.
      push    = (cnt_app == CW'(WIDTH)) || (bus.i_flush && (cnt_app != '0));
      cnt_d   = push ? '0 : cnt_app;
      shreg_d = push ? '0 : word_app;
   end

   // Buffer update: pop first, so a full buffer can accept a push in the same cycle.
   always_comb begin
      pop         = valid_q & bus.o_ready;
      head_data_d = head_data_q;
      head_cnt_d  = head_cnt_q;
      tail_data_d = tail_data_q;
      tail_cnt_d  = tail_cnt_q;
      occ_d       = occ_q;
      ovf_d       = ovf_q;

      if (pop) begin
         occ_d = occ_q - 2'd1;
         if (occ_q == 2'd2) begin
            head_data_d = tail_data_q;
            head_cnt_d  = tail_cnt_q;
         end
      end

      if (push) begin
         if (occ_d == 2'd0) begin
            head_data_d = word_app;
            head_cnt_d  = cnt_app;
            occ_d       = 2'd1;
         end else if (occ_d == 2'd1) begin
            tail_data_d = word_app;
            tail_cnt_d  = cnt_app;
            occ_d       = 2'd2;
         end else begin
            // No room: drop the word, leave buffered entries alone.
            ovf_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         shreg_q     <= '0;
         head_data_q <= '0;
         head_cnt_q  <= '0;
         tail_data_q <= '0;
         tail_cnt_q  <= '0;
         occ_q       <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         head_data_q <= head_data_d;
         head_cnt_q  <= head_cnt_d;
         tail_data_q <= tail_data_d;
         tail_cnt_q  <= tail_cnt_d;
         occ_q       <= occ_d;
         valid_q     <= (occ_d != 2'd0);
         ovf_q       <= ovf_d;
         busy_q      <= (cnt_d != '0);
      end
   end

   assign bus.o_data  = head_data_q;
   assign bus.o_cnt   = head_cnt_q;
   assign bus.o_valid = valid_q;
   assign bus.o_ovf   = ovf_q;
   assign bus.o_busy  = busy_q;

endmodule

// File: doc/sample_word_packer.md
Name: sample_word_packer

Overview:
- Downstream consumer of the gated-sample flop stage; that stage emits one captured bit per strobe.
- Packs the captured bit stream into WIDTH-bit words and supports an early flush of a partial word.
- Words go out through a 2-entry output buffer with a valid/ready handshake.
- Sticky overflow flag when a completed word arrives and no buffer space is available.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
MSB_FIRST, 1, 1: first received bit lands in bit WIDTH-1; 0: first received bit lands in bit 0

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
i_bit  input  1  sampled bit from upstream stage
i_stb  input  1  i_bit valid this cycle (one bit per strobe cycle)
i_flush  input  1  emit current partial word
o_data  output  WIDTH  head word of output buffer
o_cnt  output  $clog2(WIDTH+1)  number of valid bits in o_data (WIDTH for full words)
o_valid  output  1  o_data/o_cnt valid
o_ready  input  1  consumer accepts; transfer when o_valid & o_ready
o_ovf  output  1  sticky overflow; cleared only by reset
o_busy  output  1  partial word in progress (bit count != 0)

Behaviour:
- Reset, synchronous: bit count=0; shift register=0; buffer empty; o_valid=0; o_data=0; o_cnt=0; o_ovf=0; o_busy=0. Reset asserted mid-word discards the partial word and all buffered words.
- Bit placement: the k-th bit of a word (k=0 first) goes to position WIDTH-1-k if MSB_FIRST=1, else position k. Unfilled positions read 0.
- Strobe: each cycle with i_stb=1 stores i_bit and increments the count.
  - When the count reaches WIDTH, the word is pushed with o_cnt=WIDTH.
  - The count returns to 0 in the same cycle.
- Flush with count=0, no strobe: ignored; no push.
- Flush with count>0: pushes the partial word with o_cnt=count, then clears the count.
- Strobe and flush in the same cycle: the bit is appended first, then the flush acts on the result.
  - If the bit completed a word, exactly one word is pushed (o_cnt=WIDTH).
  - Otherwise the partial word, including that bit, is pushed.
- Output buffer: 2-entry FIFO; o_data/o_cnt always show the head entry.
  - Push appears on o_valid the cycle after the completing strobe or flush (latency 1).
  - No combinational path from i_stb or i_flush to o_valid.
  - Pop happens when o_valid & o_ready.
  - While o_valid=1 and o_ready=0, o_data and o_cnt must not change.
  - o_valid deasserts only after a pop that empties the FIFO.
- Full buffer:
  - Push and pop in the same cycle: the pop is processed first and the push is accepted.
  - Push with no pop: the new word is dropped and o_ovf is set on the next cycle.
  - Buffer contents are untouched; packing continues from count 0.
- o_ready is ignored while o_valid=0.
- o_busy = (count != 0), registered state.

Test Plan:
- WIDTH=8, MSB_FIRST=1; strobes with bits 1,0,1,1,0,0,1,0, o_ready=1 -> one cycle after the 8th strobe: o_valid=1, o_data=8'hB2, o_cnt=8; o_valid drops the next cycle.
- MSB_FIRST=0; same bit sequence -> o_data=8'h4D, o_cnt=8.
- MSB_FIRST=1; strobes 1,1,1 then i_flush -> o_data=8'hE0, o_cnt=3, o_busy returns to 0.
  - A flush with count=0 produces no word.
- o_ready=0; stream three full words (8'h01, 8'h02, 8'h03) -> buffer holds 01, 02; 03 is dropped and o_ovf=1.
  - Then o_ready=1 -> 01 and 02 are delivered in order; o_ovf stays 1.
- Buffer full, o_ready=1 in the same cycle as the completing strobe -> no drop, o_ovf stays 0, three words delivered in order.
- Strobe and flush on the 8th bit -> exactly one word with o_cnt=8.
  - Reset asserted after 5 bits -> no word emitted; o_busy=0 and o_valid=0 the cycle after reset.
